// File: rtl/pe_seq_ctrl_pkg.sv
// Shared widths and sequencer state encodings for the PE load/compute sequencer.
package pe_seq_ctrl_pkg;

    localparam int DATA_W       = 8;
    localparam int CNT_W        = 8;
    localparam int DONE_TIMEOUT = 4096;

    localparam int ST_W = 4;
    typedef logic [ST_W-1:0] pe_seq_state_t;

    localparam pe_seq_state_t ST_IDLE  = 4'd0;
    localparam pe_seq_state_t ST_LOADW = 4'd1;
    localparam pe_seq_state_t ST_GAPW  = 4'd2;
    localparam pe_seq_state_t ST_LOADA = 4'd3;
    localparam pe_seq_state_t ST_GAPA  = 4'd4;
    localparam pe_seq_state_t ST_START = 4'd5;
    localparam pe_seq_state_t ST_RUN   = 4'd6;
    localparam pe_seq_state_t ST_SUMS  = 4'd7;
    localparam pe_seq_state_t ST_DONE  = 4'd8;
    localparam pe_seq_state_t ST_ERR   = 4'd9;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Bundle of command, weight/activation streams and PE control signals around
// the sequencer. master = the sequencer, slave = cluster controller plus PE.
interface pe_seq_ctrl_if
    import pe_seq_ctrl_pkg::*;
#(
    parameter int dataSize = DATA_W,
    parameter int cntSize  = CNT_W
) ();

    logic                cmd_start;
    logic [cntSize-1:0]  cfg_wcount;
    logic [cntSize-1:0]  cfg_acount;
    logic [dataSize-1:0] w_data_i;
    logic                w_valid_i;
    logic                w_ready_o;
    logic [dataSize-1:0] a_data_i;
    logic                a_valid_i;
    logic                a_ready_o;
    logic [dataSize-1:0] weights_o;
    logic [dataSize-1:0] acts_o;
    logic                ctrl_loadw;
    logic                ctrl_loada;
    logic [cntSize-1:0]  ctrl_wcount;
    logic [cntSize-1:0]  ctrl_acount;
    logic                ctrl_start;
    logic                flag_done;
    logic                ctrl_sums;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    modport master (
        input  cmd_start, cfg_wcount, cfg_acount,
        input  w_data_i, w_valid_i, a_data_i, a_valid_i, flag_done,
        output w_ready_o, a_ready_o, weights_o, acts_o,
        output ctrl_loadw, ctrl_loada, ctrl_wcount, ctrl_acount,
        output ctrl_start, ctrl_sums, busy_o, done_o, err_o
    );

    modport slave (
        output cmd_start, cfg_wcount, cfg_acount,
        output w_data_i, w_valid_i, a_data_i, a_valid_i, flag_done,
        input  w_ready_o, a_ready_o, weights_o, acts_o,
        input  ctrl_loadw, ctrl_loada, ctrl_wcount, ctrl_acount,
        input  ctrl_start, ctrl_sums, busy_o, done_o, err_o
    );

endinterface

// File: rtl/pe_seq_ctrl_beat_cnt.sv
// Loadable down-counter with zero flag; saturates at zero so a stray decrement
// can never wrap into a huge remainder.
module pe_seq_ctrl_beat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pe_seq_ctrl.sv
// PE sequencer: loads weights then activations into one PE from valid/ready
// streams, pulses start, waits for flag_done (with timeout), then runs the
// psum systolic phase for acount-wcount+1 cycles.
module pe_seq_ctrl
    import pe_seq_ctrl_pkg::*;
#(
    parameter int dataSize    = DATA_W,
    parameter int cntSize     = CNT_W,
    parameter int doneTimeout = DONE_TIMEOUT
) (
    input  logic          clk,
    input  logic          nrst,
    pe_seq_ctrl_if.master bus
);

    // Extra bit keeps the timeout counter at least two bits wide.
    localparam int TMO_W = $clog2(doneTimeout + 1) + 1;
    localparam int SUM_W = cntSize + 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(doneTimeout - 1);

    pe_seq_state_t       state_r;
    pe_seq_state_t       state_s;

    logic                wrem_zero_s;
    logic                arem_zero_s;
    logic                sums_zero_s;
    logic                tmo_zero_s;
    logic                w_ready_s;
    logic                a_ready_s;
    logic                hs_w_s;
    logic                hs_a_s;
    logic                accept_s;
    logic                cfg_bad_s;
    logic [SUM_W-1:0]    sums_load_s;

    logic [dataSize-1:0] weights_r;
    logic [dataSize-1:0] acts_r;
    logic                loadw_r;
    logic                loada_r;
    logic [cntSize-1:0]  wcount_r;
    logic [cntSize-1:0]  acount_r;
    logic                start_r;
    logic                sums_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    // Stream ready only while beats remain in the matching load phase.
    assign w_ready_s = (state_r == ST_LOADW) && !wrem_zero_s;
    assign a_ready_s = (state_r == ST_LOADA) && !arem_zero_s;
    assign hs_w_s    = bus.w_valid_i && w_ready_s;
    assign hs_a_s    = bus.a_valid_i && a_ready_s;

    assign accept_s  = (state_r == ST_IDLE) && bus.cmd_start;
    assign cfg_bad_s = (bus.cfg_wcount == {cntSize{1'b0}}) ||
                       (bus.cfg_acount < bus.cfg_wcount);

    // Counter holds remaining SUMS cycles minus one, so zero marks the last.
    assign sums_load_s = {1'b0, bus.cfg_acount} - {1'b0, bus.cfg_wcount};

    pe_seq_ctrl_beat_cnt #(.W(cntSize)) u_wrem (
        .clk      (clk),
        .nrst     (nrst),
        .load     (accept_s),
        .load_val (bus.cfg_wcount),
        .dec      (hs_w_s),
        .zero     (wrem_zero_s)
    );

    pe_seq_ctrl_beat_cnt #(.W(cntSize)) u_arem (
        .clk      (clk),
        .nrst     (nrst),
        .load     (accept_s),
        .load_val (bus.cfg_acount),
        .dec      (hs_a_s),
        .zero     (arem_zero_s)
    );

    pe_seq_ctrl_beat_cnt #(.W(SUM_W)) u_sums (
        .clk      (clk),
        .nrst     (nrst),
        .load     (accept_s),
        .load_val (sums_load_s),
        .dec      (state_r == ST_SUMS),
        .zero     (sums_zero_s)
    );

    // Armed in GAPA and counted from the START cycle on, so the error lands
    // exactly doneTimeout cycles after ctrl_start.
    pe_seq_ctrl_beat_cnt #(.W(TMO_W)) u_tmo (
        .clk      (clk),
        .nrst     (nrst),
        .load     (state_r == ST_GAPA),
        .load_val (TMO_LOAD),
        .dec      ((state_r == ST_START) || (state_r == ST_RUN)),
        .zero     (tmo_zero_s)
    );

    // Next-state decode of the load/start/run/sums sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_start) begin
                    if (cfg_bad_s) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_LOADW;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOADW: begin
                if (wrem_zero_s) begin
                    state_s = ST_GAPW;
                end else begin
                    state_s = ST_LOADW;
                end
            end
            ST_GAPW:  state_s = ST_LOADA;
            ST_LOADA: begin
                if (arem_zero_s) begin
                    state_s = ST_GAPA;
                end else begin
                    state_s = ST_LOADA;
                end
            end
            ST_GAPA:  state_s = ST_START;
            ST_START: state_s = ST_RUN;
            ST_RUN: begin
                if (bus.flag_done) begin
                    state_s = ST_SUMS;
                end else if (tmo_zero_s) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_SUMS: begin
                if (sums_zero_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SUMS;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            ST_ERR:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register and phase outputs, registered from the next state so
    // each strobe coincides exactly with its state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
            start_r <= 1'b0;
            sums_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            start_r <= (state_s == ST_START);
            sums_r  <= (state_s == ST_SUMS);
            done_r  <= (state_s == ST_DONE);
            err_r   <= (state_s == ST_ERR);
            busy_r  <= (state_s != ST_IDLE) && (state_s != ST_DONE) &&
                       (state_s != ST_ERR);
        end
    end

    // Handshake registers: an accepted beat shows up on the PE side one
    // cycle later with its load strobe; no beat means the PE skips.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            weights_r <= {dataSize{1'b0}};
            acts_r    <= {dataSize{1'b0}};
            loadw_r   <= 1'b0;
            loada_r   <= 1'b0;
        end else begin
            loadw_r <= hs_w_s;
            loada_r <= hs_a_s;
            if (hs_w_s) begin
                weights_r <= bus.w_data_i;
            end
            if (hs_a_s) begin
                acts_r <= bus.a_data_i;
            end
        end
    end

    // Command configuration, held until the next accepted command.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wcount_r <= {cntSize{1'b0}};
            acount_r <= {cntSize{1'b0}};
        end else if (accept_s) begin
            wcount_r <= bus.cfg_wcount;
            acount_r <= bus.cfg_acount;
        end
    end

    assign bus.w_ready_o   = w_ready_s;
    assign bus.a_ready_o   = a_ready_s;
    assign bus.weights_o   = weights_r;
    assign bus.acts_o      = acts_r;
    assign bus.ctrl_loadw  = loadw_r;
    assign bus.ctrl_loada  = loada_r;
    assign bus.ctrl_wcount = wcount_r;
    assign bus.ctrl_acount = acount_r;
    assign bus.ctrl_start  = start_r;
    assign bus.ctrl_sums   = sums_r;
    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.err_o       = err_r;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: streams, error paths, timeout, async reset.
module tb_pe_seq_ctrl;

    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int TMO = 16;

    logic clk;
    logic nrst;

    pe_seq_ctrl_if #(.dataSize(DW), .cntSize(CW)) bus ();

    pe_seq_ctrl #(.dataSize(DW), .cntSize(CW), .doneTimeout(TMO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int total;
    int bad;
    int cyc_n, cmd_at, start_at, sums_at, done_at, err_at;
    int n_loadw, n_loada, n_start, n_sums, n_done, n_err, n_busy, n_multi;
    int n_lw_bad, n_la_bad, n_hs_w, n_hs_a, n_busy_done;
    int run_w, run_a, max_w, max_a;
    int w_mode, a_mode, fd_delay;
    logic prev_hs_w, prev_hs_a;
    logic [DW-1:0] last_w, last_a;
    bit fin;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int out_ones();
        return $countones({bus.busy_o, bus.done_o, bus.err_o, bus.ctrl_loadw,
                           bus.ctrl_loada, bus.ctrl_start, bus.ctrl_sums,
                           bus.w_ready_o, bus.a_ready_o, bus.weights_o,
                           bus.acts_o, bus.ctrl_wcount, bus.ctrl_acount});
    endfunction

    task automatic clear_mon();
        n_loadw = 0; n_loada = 0; n_start = 0; n_sums = 0; n_done = 0;
        n_err = 0; n_busy = 0; n_multi = 0; n_lw_bad = 0; n_la_bad = 0;
        n_hs_w = 0; n_hs_a = 0; n_busy_done = 0;
        run_w = 0; run_a = 0; max_w = 0; max_a = 0;
        start_at = -1000; sums_at = -1000; done_at = -1000; err_at = -1000;
        prev_hs_w = 1'b0; prev_hs_a = 1'b0;
    endtask

    // One clock: sample at negedge, then drive sources just after posedge.
    task automatic cyc();
        logic hs_w, hs_a;
        @(negedge clk);
        hs_w = bus.w_valid_i & bus.w_ready_o;
        hs_a = bus.a_valid_i & bus.a_ready_o;
        if (hs_w) n_hs_w++;
        if (hs_a) n_hs_a++;
        if (bus.ctrl_loadw !== prev_hs_w) n_lw_bad++;
        if (bus.ctrl_loada !== prev_hs_a) n_la_bad++;
        if (bus.ctrl_loadw === 1'b1 && bus.weights_o !== last_w) n_lw_bad++;
        if (bus.ctrl_loada === 1'b1 && bus.acts_o !== last_a) n_la_bad++;
        if (bus.ctrl_loadw) n_loadw++;
        if (bus.ctrl_loada) n_loada++;
        run_w = bus.ctrl_loadw ? run_w + 1 : 0;
        run_a = bus.ctrl_loada ? run_a + 1 : 0;
        if (run_w > max_w) max_w = run_w;
        if (run_a > max_a) max_a = run_a;
        if (bus.ctrl_start) begin n_start++; start_at = cyc_n; end
        if (bus.ctrl_sums) begin
            if (n_sums == 0) sums_at = cyc_n;
            n_sums++;
        end
        if (bus.done_o) begin
            n_done++; done_at = cyc_n;
            if (bus.busy_o) n_busy_done++;
        end
        if (bus.err_o) begin n_err++; err_at = cyc_n; end
        if (bus.busy_o) n_busy++;
        if ($countones({bus.ctrl_loadw, bus.ctrl_loada, bus.ctrl_start, bus.ctrl_sums}) > 1)
            n_multi++;
        prev_hs_w = hs_w;
        prev_hs_a = hs_a;
        if (hs_w) last_w = bus.w_data_i;
        if (hs_a) last_a = bus.a_data_i;
        @(posedge clk);
        #1;
        cyc_n++;
        if (hs_w) bus.w_data_i = bus.w_data_i + 8'd1;
        if (hs_a) bus.a_data_i = bus.a_data_i + 8'd3;
        bus.w_valid_i = (w_mode == 1) || ((w_mode == 2) && cyc_n[0]);
        bus.a_valid_i = (a_mode == 1) || ((a_mode == 2) && cyc_n[0]);
        bus.flag_done = (fd_delay > 0) && (n_start > 0) && (cyc_n == start_at + fd_delay);
    endtask

    task automatic start_cmd(input int w, input int a);
        bus.cfg_wcount = CW'(w);
        bus.cfg_acount = CW'(a);
        bus.cmd_start  = 1'b1;
        cmd_at = cyc_n;
        cyc();
        bus.cmd_start = 1'b0;
    endtask

    task automatic set_modes(input int wm, input int am, input int fd);
        w_mode = wm; a_mode = am; fd_delay = fd;
        bus.w_valid_i = (wm != 0);
        bus.a_valid_i = (am != 0);
    endtask

    // Run until done/err (bounded), optionally re-issuing cmd_start in RUN.
    task automatic run_cmd(input string tag, input int w, input int a,
                           input int wm, input int am, input int fd, input bit poke);
        clear_mon();
        set_modes(wm, am, fd);
        start_cmd(w, a);
        fin = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            if (poke && n_start == 1 && cyc_n == start_at + 2) begin
                bus.cmd_start = 1'b1; bus.cfg_wcount = 8'd0; bus.cfg_acount = 8'd0;
            end else begin
                bus.cmd_start = 1'b0;
            end
            cyc();
            if (n_done > 0 || n_err > 0) fin = 1'b1;
        end
        bus.cmd_start = 1'b0;
        repeat (3) cyc();
        check_val({tag, "_finished"}, int'(fin), 1);
    endtask

    initial begin
        total = 0; bad = 0; cyc_n = 0; cmd_at = 0;
        clk = 1'b0;
        nrst = 1'b1;
        bus.cmd_start = 1'b0; bus.cfg_wcount = 8'd0; bus.cfg_acount = 8'd0;
        bus.w_data_i = 8'h10; bus.a_data_i = 8'h80;
        bus.w_valid_i = 1'b0; bus.a_valid_i = 1'b0; bus.flag_done = 1'b0;
        last_w = 8'd0; last_a = 8'd0;
        set_modes(0, 0, 0);
        clear_mon();
        #2 nrst = 1'b0;
        @(posedge clk);
        #1;
        check_val("reset_outs", out_ones(), 0);
        cyc(); cyc();
        nrst = 1'b1;
        cyc();
        check_val("idle_outs", out_ones(), 0);

        // w=3, a=16, streams always valid
        run_cmd("t1", 3, 16, 1, 1, 3, 1'b0);
        check_val("t1_loadw", n_loadw, 3);
        check_val("t1_loadw_run", max_w, 3);
        check_val("t1_loada", n_loada, 16);
        check_val("t1_loada_run", max_a, 16);
        check_val("t1_start", n_start, 1);
        check_val("t1_sums", n_sums, 14);
        check_val("t1_done", n_done, 1);
        check_val("t1_err", n_err, 0);
        check_val("t1_onehot", n_multi, 0);
        check_val("t1_lw_data", n_lw_bad, 0);
        check_val("t1_la_data", n_la_bad, 0);
        check_val("t1_hs_w", n_hs_w, 3);
        check_val("t1_hs_a", n_hs_a, 16);
        check_val("t1_start_lat", start_at - cmd_at, 24);
        check_val("t1_sums_lat", sums_at - start_at, 4);
        check_val("t1_done_lat", done_at - cmd_at, 42);
        check_val("t1_busy_cycles", n_busy, 41);
        check_val("t1_busy_at_done", n_busy_done, 0);
        check_val("t1_wcount", int'(bus.ctrl_wcount), 3);
        check_val("t1_acount", int'(bus.ctrl_acount), 16);

        // Same with both valids toggling
        run_cmd("t2", 3, 16, 2, 2, 3, 1'b0);
        check_val("t2_loadw", n_loadw, 3);
        check_val("t2_loadw_run", max_w, 1);
        check_val("t2_loada", n_loada, 16);
        check_val("t2_loada_run", max_a, 1);
        check_val("t2_lw_data", n_lw_bad, 0);
        check_val("t2_la_data", n_la_bad, 0);
        check_val("t2_sums", n_sums, 14);
        check_val("t2_done", n_done, 1);
        check_val("t2_onehot", n_multi, 0);

        // Bad configs
        run_cmd("t3", 0, 5, 1, 1, 2, 1'b0);
        check_val("t3_err", n_err, 1);
        check_val("t3_err_lat", err_at - cmd_at, 1);
        check_val("t3_ctrl_act", n_loadw + n_loada + n_start + n_sums, 0);
        check_val("t3_busy", n_busy, 0);
        check_val("t3_hs", n_hs_w + n_hs_a, 0);
        check_val("t3_done", n_done, 0);
        run_cmd("t4", 3, 2, 1, 1, 2, 1'b0);
        check_val("t4_err", n_err, 1);
        check_val("t4_ctrl_act", n_loadw + n_loada + n_start + n_sums, 0);
        check_val("t4_busy", n_busy, 0);

        // flag_done never arrives
        run_cmd("t5", 1, 1, 1, 1, 0, 1'b0);
        check_val("t5_err", n_err, 1);
        check_val("t5_err_lat", err_at - start_at, TMO);
        check_val("t5_sums", n_sums, 0);
        check_val("t5_done", n_done, 0);
        check_val("t5_busy_after", int'(bus.busy_o), 0);

        // Async reset in the middle of LOADA, then a fresh command
        clear_mon();
        set_modes(1, 1, 0);
        start_cmd(3, 16);
        repeat (10) cyc();
        check_val("t6_in_loada", int'(bus.a_ready_o), 1);
        nrst = 1'b0;
        #1;
        check_val("t6_async_outs", out_ones(), 0);
        cyc();
        nrst = 1'b1;
        run_cmd("t6", 2, 5, 1, 1, 2, 1'b0);
        check_val("t6_done", n_done, 1);
        check_val("t6_err", n_err, 0);
        check_val("t6_loadw", n_loadw, 2);
        check_val("t6_loada", n_loada, 5);
        check_val("t6_sums", n_sums, 4);
        check_val("t6_sums_lat", sums_at - start_at, 3);
        check_val("t6_data", n_lw_bad + n_la_bad, 0);
        check_val("t6_onehot", n_multi, 0);

        // acount == wcount, cmd_start poked during RUN
        run_cmd("t7", 4, 4, 1, 1, 6, 1'b1);
        check_val("t7_sums", n_sums, 1);
        check_val("t7_done", n_done, 1);
        check_val("t7_err", n_err, 0);
        check_val("t7_start", n_start, 1);
        check_val("t7_sums_lat", sums_at - start_at, 7);
        check_val("t7_done_lat", done_at - sums_at, 1);
        check_val("t7_wcount", int'(bus.ctrl_wcount), 4);
        check_val("t7_busy_at_done", n_busy_done, 0);
        check_val("t7_busy_after", int'(bus.busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
